// File: rtl/axil_strobe_pkg.sv
// Shared types and constants for the AXI-Lite strobe master.
// DRAIN exists only with AXIL_STROBE_MASTER_TIMEOUT_EN.
package axil_strobe_pkg;

`ifdef AXIL_STROBE_MASTER_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_WREQ,
    S_WRESP,
    S_RREQ,
    S_RDATA,
    S_DRAIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_WREQ,
    S_WRESP,
    S_RREQ,
    S_RDATA
  } state_t;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Anything other than OKAY is reported as an error.
  function automatic logic resp_err(input logic [1:0] r);
    logic e;
    unique case (r)
      RESP_OKAY:                e = 1'b0;
      RESP_SLVERR, RESP_DECERR: e = 1'b1;
      default:                  e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/axil_strobe_master.sv
// Strobe/ack register requests to AXI-Lite master transactions.
// Define AXIL_STROBE_MASTER_TIMEOUT_EN for handshake timeouts.
module axil_strobe_master
  import axil_strobe_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        axilClk,
  input  logic        axilRstL,
  input  logic        cmd_wstr,
  input  logic        cmd_rstr,
  input  logic [17:0] cmd_addr,
  input  logic [31:0] cmd_din,
  output logic [31:0] cmd_dout,
  output logic        cmd_wack,
  output logic        cmd_rack,
  output logic        cmd_err,
  output logic        cmd_busy,
  output logic [31:0] axilWriteMaster_awaddr,
  output logic [2:0]  axilWriteMaster_awprot,
  output logic        axilWriteMaster_awvalid,
  input  logic        axilWriteSlave_awready,
  output logic [31:0] axilWriteMaster_wdata,
  output logic [3:0]  axilWriteMaster_wstrb,
  output logic        axilWriteMaster_wvalid,
  input  logic        axilWriteSlave_wready,
  input  logic [1:0]  axilWriteSlave_bresp,
  input  logic        axilWriteSlave_bvalid,
  output logic        axilWriteMaster_bready,
  output logic [31:0] axilReadMaster_araddr,
  output logic [2:0]  axilReadMaster_arprot,
  output logic        axilReadMaster_arvalid,
  input  logic        axilReadSlave_arready,
  input  logic [31:0] axilReadSlave_rdata,
  input  logic [1:0]  axilReadSlave_rresp,
  input  logic        axilReadSlave_rvalid,
  output logic        axilReadMaster_rready
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] awaddr_d, wdata_d, araddr_d;
  logic        awv_d, wv_d, arv_d;
  logic        bready_d, rready_d;
  logic        wack_d, rack_d, err_d, busy_d;
  logic [31:0] dout_d;
  logic [31:0] cmd_byte;

  assign cmd_byte = {ADDR_BASE[31:20], cmd_addr, 2'b00};

  assign axilWriteMaster_awprot = 3'b000;
  assign axilReadMaster_arprot  = 3'b000;
  assign axilWriteMaster_wstrb  = 4'hF;

`ifdef AXIL_STROBE_MASTER_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        wait_st, tmo;

  assign wait_st = state_q inside {S_WREQ, S_WRESP,
                                   S_RREQ, S_RDATA};
  assign tmo = wait_st &&
               (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Cycles spent in the current waiting state.
  always_ff @(posedge axilClk) begin
    if (!axilRstL || state_d != state_q)
      cnt_q <= '0;
    else if (wait_st)
      cnt_q <= cnt_q + 32'd1;
  end
`endif

  // Next state and next value of every registered output.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    awaddr_d = axilWriteMaster_awaddr;
    wdata_d  = axilWriteMaster_wdata;
    araddr_d = axilReadMaster_araddr;
    awv_d    = axilWriteMaster_awvalid;
    wv_d     = axilWriteMaster_wvalid;
    arv_d    = axilReadMaster_arvalid;
    bready_d = axilWriteMaster_bready;
    rready_d = axilReadMaster_rready;
    dout_d   = cmd_dout;
    wack_d   = 1'b0;
    rack_d   = 1'b0;
    err_d    = 1'b0;
    if (axilWriteSlave_awready) awv_d = 1'b0;
    if (axilWriteSlave_wready)  wv_d  = 1'b0;
    if (axilReadSlave_arready)  arv_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        awv_d = 1'b0;
        wv_d  = 1'b0;
        arv_d = 1'b0;
        if (pend_q) begin
          pend_d  = 1'b0;
          arv_d   = 1'b1;
          state_d = S_RREQ;
        end else if (!cmd_busy && cmd_wstr) begin
          awaddr_d = cmd_byte;
          wdata_d  = cmd_din;
          awv_d    = 1'b1;
          wv_d     = 1'b1;
          state_d  = S_WREQ;
          if (cmd_rstr) begin
            araddr_d = cmd_byte;
            pend_d   = 1'b1;
          end
        end else if (!cmd_busy && cmd_rstr) begin
          araddr_d = cmd_byte;
          arv_d    = 1'b1;
          state_d  = S_RREQ;
        end
      end
      S_WREQ: begin
        if (!awv_d && !wv_d) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (axilWriteSlave_bvalid) begin
          wack_d   = 1'b1;
          err_d    = resp_err(axilWriteSlave_bresp);
          bready_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_RREQ: begin
        if (!arv_d) begin
          rready_d = 1'b1;
          state_d  = S_RDATA;
        end
      end
      S_RDATA: begin
        if (axilReadSlave_rvalid) begin
          dout_d   = axilReadSlave_rdata;
          rack_d   = 1'b1;
          err_d    = resp_err(axilReadSlave_rresp);
          rready_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
`ifdef AXIL_STROBE_MASTER_TIMEOUT_EN
      S_DRAIN: begin
        if ((axilWriteSlave_bvalid &&
             axilWriteMaster_bready) ||
            (axilReadSlave_rvalid &&
             axilReadMaster_rready)) begin
          bready_d = 1'b0;
          rready_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef AXIL_STROBE_MASTER_TIMEOUT_EN
    if (tmo && state_d == state_q) begin
      state_d = S_DRAIN;
      err_d   = 1'b1;
      if (state_q inside {S_WREQ, S_WRESP}) begin
        wack_d   = 1'b1;
        bready_d = 1'b1;
      end else begin
        rack_d   = 1'b1;
        rready_d = 1'b1;
        dout_d   = TIMEOUT_DATA;
      end
    end
`endif
    busy_d = (state_d != S_IDLE) || pend_d ||
             wack_d || rack_d;
  end

  // State and output registers.
  always_ff @(posedge axilClk) begin
    if (!axilRstL) begin
      state_q                 <= S_IDLE;
      pend_q                  <= 1'b0;
      axilWriteMaster_awaddr  <= '0;
      axilWriteMaster_wdata   <= '0;
      axilReadMaster_araddr   <= '0;
      axilWriteMaster_awvalid <= 1'b0;
      axilWriteMaster_wvalid  <= 1'b0;
      axilReadMaster_arvalid  <= 1'b0;
      axilWriteMaster_bready  <= 1'b0;
      axilReadMaster_rready   <= 1'b0;
      cmd_dout                <= '0;
      cmd_wack                <= 1'b0;
      cmd_rack                <= 1'b0;
      cmd_err                 <= 1'b0;
      cmd_busy                <= 1'b0;
    end else begin
      state_q                 <= state_d;
      pend_q                  <= pend_d;
      axilWriteMaster_awaddr  <= awaddr_d;
      axilWriteMaster_wdata   <= wdata_d;
      axilReadMaster_araddr   <= araddr_d;
      axilWriteMaster_awvalid <= awv_d;
      axilWriteMaster_wvalid  <= wv_d;
      axilReadMaster_arvalid  <= arv_d;
      axilWriteMaster_bready  <= bready_d;
      axilReadMaster_rready   <= rready_d;
      cmd_dout                <= dout_d;
      cmd_wack                <= wack_d;
      cmd_rack                <= rack_d;
      cmd_err                 <= err_d;
      cmd_busy                <= busy_d;
    end
  end

endmodule

// File: tb/tb_axil_strobe_master.sv
// Directed scoreboard bench for axil_strobe_master.
// The timeout scenario runs when AXIL_STROBE_MASTER_TIMEOUT_EN is defined.
module tb_axil_strobe_master;

  localparam logic [31:0] BASE = 32'hA5B0_0000;

  logic clk = 1'b0;
  logic rstL = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_wstr, cmd_rstr;
  logic [17:0] cmd_addr;
  logic [31:0] cmd_din, cmd_dout;
  logic        cmd_wack, cmd_rack, cmd_err, cmd_busy;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;
  logic [1:0]  bresp, rresp;

  axil_strobe_master #(
    .ADDR_BASE(BASE),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .axilClk(clk),
    .axilRstL(rstL),
    .cmd_wstr(cmd_wstr),
    .cmd_rstr(cmd_rstr),
    .cmd_addr(cmd_addr),
    .cmd_din(cmd_din),
    .cmd_dout(cmd_dout),
    .cmd_wack(cmd_wack),
    .cmd_rack(cmd_rack),
    .cmd_err(cmd_err),
    .cmd_busy(cmd_busy),
    .axilWriteMaster_awaddr(awaddr),
    .axilWriteMaster_awprot(awprot),
    .axilWriteMaster_awvalid(awvalid),
    .axilWriteSlave_awready(awready),
    .axilWriteMaster_wdata(wdata),
    .axilWriteMaster_wstrb(wstrb),
    .axilWriteMaster_wvalid(wvalid),
    .axilWriteSlave_wready(wready),
    .axilWriteSlave_bresp(bresp),
    .axilWriteSlave_bvalid(bvalid),
    .axilWriteMaster_bready(bready),
    .axilReadMaster_araddr(araddr),
    .axilReadMaster_arprot(arprot),
    .axilReadMaster_arvalid(arvalid),
    .axilReadSlave_arready(arready),
    .axilReadSlave_rdata(rdata),
    .axilReadSlave_rresp(rresp),
    .axilReadSlave_rvalid(rvalid),
    .axilReadMaster_rready(rready)
  );

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_aw = 0, n_ar = 0, n_b = 0, n_r = 0;
  int n_wack = 0, n_rack = 0;

  int aw_wait = 0, w_wait = 0, b_wait = 0;
  int ar_wait = 0, r_wait = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;

  bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
  bit aw_done, w_done, ar_done;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int what);
    case (what)
      0:       return cmd_wack || cmd_rack;
      1:       return !cmd_busy;
      2:       return bready;
      3:       return !arvalid;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_until(input int what,
                            input int budget,
                            input string tag);
    int k = 0;
    while (!cond(what) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, cond(what)}, 1);
  endtask

  task automatic do_write(input logic [17:0] a,
                          input logic [31:0] d,
                          input bit err);
    exp_t e;
    e.rd = 1'b0; e.err = err; e.data = '0;
    sb.push_back(e);
    cmd_addr = a; cmd_din = d; cmd_wstr = 1'b1;
    tick();
    cmd_wstr = 1'b0;
  endtask

  task automatic do_read(input logic [17:0] a,
                         input logic [31:0] d,
                         input bit err);
    exp_t e;
    e.rd = 1'b1; e.err = err; e.data = d;
    sb.push_back(e);
    cmd_addr = a; cmd_rstr = 1'b1;
    tick();
    cmd_rstr = 1'b0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_awvalid"}, awvalid, 0);
    chk({p, "_wvalid"}, wvalid, 0);
    chk({p, "_arvalid"}, arvalid, 0);
    chk({p, "_bready"}, bready, 0);
    chk({p, "_rready"}, rready, 0);
    chk({p, "_wack"}, cmd_wack, 0);
    chk({p, "_rack"}, cmd_rack, 0);
    chk({p, "_err"}, cmd_err, 0);
    chk({p, "_busy"}, cmd_busy, 0);
    chk({p, "_dout"}, cmd_dout, 0);
    chk({p, "_awaddr"}, awaddr, 0);
    chk({p, "_wdata"}, wdata, 0);
    chk({p, "_araddr"}, araddr, 0);
  endtask

  // Handshake observer (pre-edge values).
  always @(posedge clk) begin
    aw_hs = rstL && awvalid && awready;
    w_hs  = rstL && wvalid && wready;
    b_hs  = rstL && bvalid && bready;
    ar_hs = rstL && arvalid && arready;
    r_hs  = rstL && rvalid && rready;
    if (aw_hs) n_aw++;
    if (ar_hs) n_ar++;
    if (b_hs)  n_b++;
    if (r_hs)  n_r++;
  end

  // Slave model, driven on the falling edge.
  always @(negedge clk) begin
    if (!rstL) begin
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_done = 0; w_done = 0; ar_done = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      ar_cnt = 0; r_cnt = 0;
    end else begin
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      if (ar_hs) ar_done = 1;
      if (b_hs) begin
        bvalid = 0; aw_done = 0; w_done = 0;
      end
      if (r_hs) begin
        rvalid = 0; ar_done = 0;
      end
      awready = 0; wready = 0; arready = 0;
      if (awvalid && !aw_done) begin
        if (aw_cnt >= aw_wait) begin
          awready = 1; aw_cnt = 0;
        end else aw_cnt++;
      end
      if (wvalid && !w_done) begin
        if (w_cnt >= w_wait) begin
          wready = 1; w_cnt = 0;
        end else w_cnt++;
      end
      if (arvalid && !ar_done) begin
        if (ar_cnt >= ar_wait) begin
          arready = 1; ar_cnt = 0;
        end else ar_cnt++;
      end
      if (aw_done && w_done && !bvalid) begin
        if (b_cnt >= b_wait) begin
          bvalid = 1; bresp = bresp_cfg; b_cnt = 0;
        end else b_cnt++;
      end
      if (ar_done && !rvalid) begin
        if (r_cnt >= r_wait) begin
          rvalid = 1; rresp = rresp_cfg;
          rdata = rdata_cfg; r_cnt = 0;
        end else r_cnt++;
      end
    end
  end

  // Scoreboard: every ack pops and checks one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rstL && (cmd_wack || cmd_rack)) begin
      if (cmd_wack) n_wack++;
      if (cmd_rack) n_rack++;
      if (sb.size() == 0) begin
        chk("ack_unexpected",
            {31'b0, cmd_wack | cmd_rack}, 0);
      end else begin
        e = sb.pop_front();
        chk("ack_is_rd", {31'b0, cmd_rack}, {31'b0, e.rd});
        chk("ack_is_wr", {31'b0, cmd_wack}, {31'b0, !e.rd});
        chk("ack_err", {31'b0, cmd_err}, {31'b0, e.err});
        if (e.rd) chk("ack_rdata", cmd_dout, e.data);
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, aw0, ar0, rr0, gap, cyc;
    logic [31:0] ar_seen;
    cmd_wstr = 0; cmd_rstr = 0;
    cmd_addr = '0; cmd_din = '0;
    rstL = 0;
    tick(3);
    chk_zero("rst");
    rstL = 1;
    tick();

    // zero-wait write
    do_write(18'h00010, 32'h1234_5678, 0);
    chk("t1_awvalid", awvalid, 1);
    chk("t1_awaddr", awaddr, BASE | 32'h40);
    chk("t1_wvalid", wvalid, 1);
    chk("t1_wdata", wdata, 32'h1234_5678);
    chk("t1_wstrb", wstrb, 4'hF);
    chk("t1_awprot", awprot, 0);
    chk("t1_busy", cmd_busy, 1);
    tick(2);
    chk("t1_wack_c3", cmd_wack, 1);
    chk("t1_err_c3", cmd_err, 0);
    chk("t1_busy_c3", cmd_busy, 1);
    tick();
    chk("t1_wack_1cyc", cmd_wack, 0);
    wait_until(1, 10, "t1_idle");

    // read with wait states
    ar_wait = 5; r_wait = 3;
    rdata_cfg = 32'hCAFE_F00D;
    r0 = n_rack;
    do_read(18'h3FFFF, 32'hCAFE_F00D, 0);
    chk("t2_arvalid", arvalid, 1);
    chk("t2_araddr", araddr, BASE | 32'h000F_FFFC);
    chk("t2_arprot", arprot, 0);
    wait_until(1, 40, "t2_idle");
    tick(3);
    chk("t2_rack_once", n_rack - r0, 1);
    chk("t2_dout_hold", cmd_dout, 32'hCAFE_F00D);
    ar_wait = 0; r_wait = 0;

    // simultaneous write and read
    rdata_cfg = 32'h0BAD_F00D;
    w0 = n_wack; r0 = n_rack;
    gap = 0; ar_seen = '0;
    begin
      exp_t e;
      e.rd = 0; e.err = 0; e.data = '0;
      sb.push_back(e);
      e.rd = 1; e.data = 32'h0BAD_F00D;
      sb.push_back(e);
    end
    cmd_addr = 18'h00123; cmd_din = 32'hA1B2_C3D4;
    cmd_wstr = 1; cmd_rstr = 1;
    tick();
    cmd_wstr = 0; cmd_rstr = 0;
    chk("t3_awaddr", awaddr, BASE | 32'h48C);
    chk("t3_no_ar_yet", arvalid, 0);
    cyc = 0;
    while (!cmd_rack && cyc < 40) begin
      if (!cmd_busy) gap++;
      if (arvalid) ar_seen = araddr;
      tick();
      cyc++;
    end
    chk("t3_rack_seen", cmd_rack, 1);
    chk("t3_busy_gap", gap, 0);
    chk("t3_wack_first", n_wack - w0, 1);
    chk("t3_araddr", ar_seen, BASE | 32'h48C);
    wait_until(1, 10, "t3_idle");

    // SLVERR write, strobes while busy ignored
    bresp_cfg = 2'b10;
    aw0 = n_aw; ar0 = n_ar;
    do_write(18'h00200, 32'hFFFF_0000, 1);
    cmd_addr = 18'h00300;
    cmd_wstr = 1; cmd_rstr = 1;
    tick(2);
    cmd_wstr = 0; cmd_rstr = 0;
    wait_until(1, 20, "t4_idle");
    tick(2);
    chk("t4_aw_count", n_aw - aw0, 1);
    chk("t4_ar_count", n_ar - ar0, 0);
    bresp_cfg = 2'b00;

    // DECERR read still updates dout
    rresp_cfg = 2'b11;
    rdata_cfg = 32'h5555_AAAA;
    do_read(18'h00040, 32'h5555_AAAA, 1);
    wait_until(1, 20, "t4b_idle");
    chk("t4b_dout", cmd_dout, 32'h5555_AAAA);
    rresp_cfg = 2'b00;

`ifdef AXIL_STROBE_MASTER_TIMEOUT_EN
    // read timeout with late arready and rvalid
    ar_wait = 30; r_wait = 2;
    rdata_cfg = 32'h1212_1212;
    r0 = n_rack; rr0 = n_r;
    do_read(18'h00077, 32'hDEAD_BEEF, 1);
    cyc = 1;
    while (!cmd_rack && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t5_latency", cyc, 17);
    chk("t5_arvalid_held", arvalid, 1);
    chk("t5_dout", cmd_dout, 32'hDEAD_BEEF);
    tick();
    chk("t5_busy_drain", cmd_busy, 1);
    chk("t5_rack_1cyc", cmd_rack, 0);
    wait_until(3, 40, "t5_ar_drop");
    wait_until(1, 40, "t5_idle");
    tick(2);
    chk("t5_r_drained", n_r - rr0, 1);
    chk("t5_rack_once", n_rack - r0, 1);
    ar_wait = 0; r_wait = 0;
`endif

    // reset during WRESP
    b_wait = 20;
    w0 = n_wack;
    do_write(18'h00444, 32'h7777_8888, 0);
    wait_until(2, 10, "t6_wresp");
    tick(2);
    rstL = 0;
    tick();
    chk_zero("t6_rst");
    sb.delete();
    tick();
    rstL = 1;
    b_wait = 0;
    tick();
    chk("t6_no_ack", n_wack - w0, 0);
    do_write(18'h00555, 32'h9999_AAAA, 0);
    chk("t6_new_wdata", wdata, 32'h9999_AAAA);
    wait_until(0, 20, "t6_new_ack");
    chk("t6_new_wack", cmd_wack, 1);
    wait_until(1, 10, "t6_idle");
    tick(2);
    chk("t6_wack_count", n_wack - w0, 1);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
